// File: rtl/cdf_divider.sv
// Iterative restoring divider for the histogram-equalization CDF path.
// One quotient bit per cycle; the result registers hold until the next completed division.
module cdf_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sc_mem_rd_en,
  input  logic [WIDTH-1:0] sc_mem_rd_data1,
  input  logic [WIDTH-1:0] sc_mem_rd_data2,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder,
  output logic             div_by_zero,
  output logic             div_busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIVIDE,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH:0]   next_rem;
  logic [WIDTH-1:0] next_q;

  // Trial subtraction is one bit wider than the shifted remainder so its MSB acts as the sign.
  always_comb begin
    shifted  = {rem, q[WIDTH-1]};
    trial    = shifted - {2'b00, divisor};
    trial_ok = ~trial[WIDTH+1];
    next_rem = trial_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
    next_q   = (q << 1) | WIDTH'(trial_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      q             <= '0;
      divisor       <= '0;
      rem           <= '0;
      cnt           <= '0;
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
      div_by_zero   <= 1'b0;
      div_busy      <= 1'b0;
    end else begin
      div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && sc_mem_rd_en) begin
            state    <= LOAD;
            div_busy <= 1'b1;
          end
        end
        LOAD: begin
          if (!enable) begin
            state    <= IDLE;
            div_busy <= 1'b0;
          end else begin
            q       <= sc_mem_rd_data1;
            divisor <= sc_mem_rd_data2;
            rem     <= '0;
            cnt     <= '0;
            // A zero divisor skips the iteration and reports a saturated quotient.
            if (sc_mem_rd_data2 == '0) begin
              state         <= DONE;
              div_busy      <= 1'b0;
              div_done      <= 1'b1;
              div_quotient  <= '1;
              div_remainder <= sc_mem_rd_data1;
              div_by_zero   <= 1'b1;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (!enable) begin
            state    <= IDLE;
            div_busy <= 1'b0;
          end else begin
            rem <= next_rem;
            q   <= next_q;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state         <= DONE;
              div_busy      <= 1'b0;
              div_done      <= 1'b1;
              div_quotient  <= next_q;
              div_remainder <= next_rem[WIDTH-1:0];
              div_by_zero   <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          div_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_divider.sv
// Self-checking bench for cdf_divider: directed timing cases plus a randomized
// regression against a plain-arithmetic reference model.
module tb_cdf_divider;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        sc_mem_rd_en;
  logic [15:0] sc_mem_rd_data1;
  logic [15:0] sc_mem_rd_data2;
  logic        div_done;
  logic [15:0] div_quotient;
  logic [15:0] div_remainder;
  logic        div_by_zero;
  logic        div_busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q = 16'h0;
  logic [15:0] exp_r = 16'h0;
  logic        exp_z = 1'b0;

  cdf_divider #(.WIDTH(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .sc_mem_rd_en    (sc_mem_rd_en),
    .sc_mem_rd_data1 (sc_mem_rd_data1),
    .sc_mem_rd_data2 (sc_mem_rd_data2),
    .div_done        (div_done),
    .div_quotient    (div_quotient),
    .div_remainder   (div_remainder),
    .div_by_zero     (div_by_zero),
    .div_busy        (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
    end
  endtask

  // kind: 0 plain, 1 extra strobe in cycle 5, 2 enable dropped in cycle 8, 3 reset in cycle 10.
  // Returns the cycle (relative to the strobe) in which div_done was seen, or -1.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input int kind,
                               output int done_cyc);
    @(negedge clk);
    sc_mem_rd_en    = 1'b1;
    sc_mem_rd_data1 = 16'($urandom);
    sc_mem_rd_data2 = 16'($urandom);
    done_cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checkOutput("busy_load", {31'b0, div_busy}, 32'd1);
        sc_mem_rd_en    = 1'b0;
        sc_mem_rd_data1 = a;
        sc_mem_rd_data2 = b;
      end else if (n == 2) begin
        sc_mem_rd_data1 = 16'($urandom);
        sc_mem_rd_data2 = 16'($urandom);
      end
      if (kind == 1 && n == 5) sc_mem_rd_en = 1'b1;
      if (kind == 1 && n == 6) sc_mem_rd_en = 1'b0;
      if (kind == 2 && n == 8) enable = 1'b0;
      if (kind == 2 && n == 9) begin
        checkOutput("abort_busy", {31'b0, div_busy}, 32'd0);
        enable = 1'b1;
      end
      if (kind == 3 && n == 10) reset = 1'b1;
      if (kind == 3 && n == 11) begin
        checkOutput("rst_mid_busy", {31'b0, div_busy}, 32'd0);
        checkOutput("rst_mid_q", {16'b0, div_quotient}, 32'd0);
        checkOutput("rst_mid_r", {16'b0, div_remainder}, 32'd0);
        checkOutput("rst_mid_z", {31'b0, div_by_zero}, 32'd0);
        reset = 1'b0;
      end
      if (div_done) begin
        checkOutput("busy_done", {31'b0, div_busy}, 32'd0);
        done_cyc = n;
        break;
      end
    end
  endtask

  // Runs one division and compares against the reference model.
  task automatic runDiv(input string tag, input logic [15:0] a, input logic [15:0] b, input int kind);
    int cyc;
    int exp_cyc;
    applyStimulus(a, b, kind, cyc);
    if (kind == 3) begin
      exp_q = 16'h0; exp_r = 16'h0; exp_z = 1'b0;
      exp_cyc = -1;
    end else if (kind == 2) begin
      exp_cyc = -1;
    end else if (b == 16'h0) begin
      exp_q = 16'hFFFF; exp_r = a; exp_z = 1'b1;
      exp_cyc = 2;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_z = 1'b0;
      exp_cyc = 18;
    end
    checkOutput({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    checkOutput({tag, "_q"}, {16'b0, div_quotient}, {16'b0, exp_q});
    checkOutput({tag, "_r"}, {16'b0, div_remainder}, {16'b0, exp_r});
    checkOutput({tag, "_z"}, {31'b0, div_by_zero}, {31'b0, exp_z});
  endtask

  task automatic checkHold(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      checkOutput({tag, "_no_done"}, {31'b0, div_done}, 32'd0);
      checkOutput({tag, "_q"}, {16'b0, div_quotient}, {16'b0, exp_q});
      checkOutput({tag, "_r"}, {16'b0, div_remainder}, {16'b0, exp_r});
    end
  endtask

  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'hFFFF;
      3:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    reset           = 1'b1;
    enable          = 1'b1;
    sc_mem_rd_en    = 1'b0;
    sc_mem_rd_data1 = 16'h0;
    sc_mem_rd_data2 = 16'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_done", {31'b0, div_done}, 32'd0);
    checkOutput("rst_busy", {31'b0, div_busy}, 32'd0);
    checkOutput("rst_q", {16'b0, div_quotient}, 32'd0);
    checkOutput("rst_r", {16'b0, div_remainder}, 32'd0);
    checkOutput("rst_z", {31'b0, div_by_zero}, 32'd0);
    reset = 1'b0;

    $display("[TB] basic 100/7");
    runDiv("d100_7", 16'd100, 16'd7, 0);
    checkHold("hold", 12);

    $display("[TB] back-to-back");
    runDiv("dffff_1", 16'hFFFF, 16'd1, 0);
    runDiv("d5_9", 16'd5, 16'd9, 0);

    $display("[TB] divide by zero");
    runDiv("d1234_0", 16'd1234, 16'd0, 0);
    runDiv("d10_3", 16'd10, 16'd3, 0);

    $display("[TB] ignored strobe");
    runDiv("dstrobe", 16'd100, 16'd7, 1);
    checkHold("strobe_hold", 20);

    $display("[TB] enable abort");
    runDiv("dabort", 16'd500, 16'd3, 2);

    $display("[TB] mid reset");
    runDiv("dreset", 16'd100, 16'd7, 3);
    runDiv("d1000_10", 16'd1000, 16'd10, 0);

    $display("[TB] random regression");
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = pickOperand();
      b = pickOperand();
      runDiv("rand", a, b, 0);
      if (b != 16'h0) begin
        checkOutput("rand_identity", 32'(div_quotient) * 32'(b) + 32'(div_remainder), 32'(a));
        checkOutput("rand_rem_lt", {31'b0, div_remainder < b}, 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
